// File: rtl/uart_rx_buffer_if.sv
// Receive buffer bus: receiver-side inputs, line-control configuration and
// the register-interface view of the buffer. The master drives characters,
// configuration and read strobes; the slave is the buffer itself.
interface uart_rx_buffer_if;
  // configuration / timing
  logic       RXCLK;
  logic       FIFOE;
  logic       CLEAR;
  logic [1:0] TL;
  logic [1:0] WLS;
  logic       PEN;
  logic       STB;
  // receiver side
  logic [7:0] DIN;
  logic       PEI;
  logic       FEI;
  logic       BII;
  logic       RXFINISHED;
  // register interface strobes
  logic       RD;
  logic       LSRREAD;
  // buffer outputs
  logic [7:0] DOUT;
  logic       DOUT_PE;
  logic       DOUT_FE;
  logic       DOUT_BI;
  logic       EMPTY;
  logic       FULL;
  logic [4:0] USAGE;
  logic       TRIGGER;
  logic       OE;
  logic       ERRINFIFO;
  logic       TIMEOUT;

  modport master (
    output RXCLK, FIFOE, CLEAR, TL, WLS, PEN, STB,
    output DIN, PEI, FEI, BII, RXFINISHED, RD, LSRREAD,
    input  DOUT, DOUT_PE, DOUT_FE, DOUT_BI, EMPTY, FULL, USAGE,
    input  TRIGGER, OE, ERRINFIFO, TIMEOUT
  );

  modport slave (
    input  RXCLK, FIFOE, CLEAR, TL, WLS, PEN, STB,
    input  DIN, PEI, FEI, BII, RXFINISHED, RD, LSRREAD,
    output DOUT, DOUT_PE, DOUT_FE, DOUT_BI, EMPTY, FULL, USAGE,
    output TRIGGER, OE, ERRINFIFO, TIMEOUT
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART 16750 receive character buffer: 16-entry FIFO of {BI,FE,PE,DATA}
// with show-ahead head, sticky overrun, error-in-FIFO tracking, trigger
// level and character timeout. Depth collapses to 1 when FIFOE=0.
module uart_rx_buffer #(
  parameter int TIMEOUT_CHARS = 4
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_buffer_if.slave bus
);

  localparam logic [9:0] TMO_SCALE = 10'(TIMEOUT_CHARS * 16);

  logic [10:0] mem_q [16];
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]  usage_q, usage_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic [9:0]  tmo_cnt_q, tmo_cnt_d;
  logic        oe_q, oe_d;

  logic [10:0] head;
  logic [10:0] wr_entry;
  logic        empty, full;
  logic        push, pop, overrun;
  logic        push_err, pop_err;
  logic [3:0]  char_bits;
  logic [9:0]  tmo_limit;
  logic [4:0]  trig_level;

  assign head     = mem_q[rd_ptr_q];
  assign wr_entry = {bus.BII, bus.FEI, bus.PEI, bus.DIN};

  // Occupancy flags; with FIFOs disabled any stored entry fills the buffer.
  assign empty = (usage_q == 5'd0);
  assign full  = bus.FIFOE ? usage_q[4] : !empty;

  // A pop in the same cycle frees the slot a full buffer would otherwise lack.
  assign pop      = bus.RD && !empty;
  assign push     = bus.RXFINISHED && (!full || pop);
  assign overrun  = bus.RXFINISHED && full && !pop && !bus.CLEAR;
  assign push_err = push && (|wr_entry[10:8]);
  assign pop_err  = pop && (|head[10:8]);

  // Character length in bits: start + data + parity + stop.
  assign char_bits = 4'd7 + {2'b00, bus.WLS} + {3'b000, bus.PEN} + {3'b000, bus.STB};
  assign tmo_limit = TMO_SCALE * {6'b000000, char_bits};

  // Next-state for pointers, occupancy, error count, timeout and overrun.
  // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usage_d   = usage_q;
    err_cnt_d = err_cnt_q;
    tmo_cnt_d = tmo_cnt_q;

    if (bus.CLEAR) begin
      wr_ptr_d  = 4'd0;
      rd_ptr_d  = 4'd0;
      usage_d   = 5'd0;
      err_cnt_d = 5'd0;
      tmo_cnt_d = 10'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 4'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 4'd1;

      case ({push, pop})
        2'b10:   usage_d = usage_q + 5'd1;
        2'b01:   usage_d = usage_q - 5'd1;
        default: usage_d = usage_q;
      endcase

      case ({push_err, pop_err})
        2'b10:   err_cnt_d = err_cnt_q + 5'd1;
        2'b01:   err_cnt_d = err_cnt_q - 5'd1;
        default: err_cnt_d = err_cnt_q;
      endcase

      // Any buffer activity or an empty buffer restarts the character timer;
      // it saturates once it has reached the current limit.
      if (push || pop || empty)
        tmo_cnt_d = 10'd0;
      else if (bus.RXCLK && bus.FIFOE && (tmo_cnt_q < tmo_limit))
        tmo_cnt_d = tmo_cnt_q + 10'd1;
    end

    // A new overrun outranks a simultaneous LSR read; CLEAR leaves OE alone.
    if (overrun)
      oe_d = 1'b1;
    else if (bus.LSRREAD)
      oe_d = 1'b0;
    else
      oe_d = oe_q;
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= 4'd0;
      rd_ptr_q  <= 4'd0;
      usage_q   <= 5'd0;
      err_cnt_q <= 5'd0;
      tmo_cnt_q <= 10'd0;
      oe_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usage_q   <= usage_d;
      err_cnt_q <= err_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      oe_q      <= oe_d;
    end
  end

  // Entry storage; a discarded push (CLEAR) never touches the array.
  // NOTE: the array is reset so DOUT reads a defined 0 out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 11'd0;
    end else if (push && !bus.CLEAR) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Trigger threshold selected by TL.
  always_comb begin
    case (bus.TL)
      2'b00:   trig_level = 5'd1;
      2'b01:   trig_level = 5'd4;
      2'b10:   trig_level = 5'd8;
      default: trig_level = 5'd14;
    endcase
  end

  assign bus.DOUT      = head[7:0];
  assign bus.DOUT_PE   = head[8];
  assign bus.DOUT_FE   = head[9];
  assign bus.DOUT_BI   = head[10];
  assign bus.EMPTY     = empty;
  assign bus.FULL      = full;
  assign bus.USAGE     = usage_q;
  assign bus.TRIGGER   = (usage_q >= trig_level);
  assign bus.OE        = oe_q;
  assign bus.ERRINFIFO = (err_cnt_q != 5'd0);
  // A counter left above a newly shortened limit still reports a timeout.
  assign bus.TIMEOUT   = bus.FIFOE && (tmo_cnt_q >= tmo_limit);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: a vector table for the basic push/pop/overrun
// behaviour, a queue scoreboard that checks every popped head, and
// hand-written sequences for fill, timeout, clear and async reset.
module tb_uart_rx_buffer;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.TIMEOUT_CHARS(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] sb_q[$];
  logic        model_oe = 1'b0;

  typedef struct {
    logic       fifoe;
    logic       rxf;
    logic [7:0] din;
    logic [2:0] flg;
    logic       rd;
    logic       lsr;
    logic       clr;
    logic [4:0] e_usage;
    logic       e_empty;
    logic       e_full;
    logic       e_oe;
    logic       e_err;
    logic       chk_dout;
    logic [10:0] e_dout;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] head_word();
    return {bus.DOUT_BI, bus.DOUT_FE, bus.DOUT_PE, bus.DOUT};
  endfunction

  // One clock of stimulus; the scoreboard predicts pushes/pops/overrun and
  // compares the head against the expected entry whenever a pop happens.
  task automatic cyc(input logic rxf, input logic [7:0] din, input logic [2:0] flg,
                     input logic rd, input logic lsr, input logic clr);
    logic full_m, pop_m, push_m, ovr_m;
    logic [10:0] exp_head;
    @(negedge CLK);
    bus.RXFINISHED = rxf;
    bus.DIN        = din;
    {bus.BII, bus.FEI, bus.PEI} = flg;
    bus.RD         = rd;
    bus.LSRREAD    = lsr;
    bus.CLEAR      = clr;
    full_m = bus.FIFOE ? (sb_q.size() == 16) : (sb_q.size() >= 1);
    pop_m  = rd && (sb_q.size() > 0) && !clr;
    push_m = rxf && !clr && (!full_m || pop_m);
    ovr_m  = rxf && !clr && full_m && !pop_m;
    #1;
    if (pop_m) begin
      exp_head = sb_q.pop_front();
      check("rd_head", 32'(head_word()), 32'(exp_head));
    end
    if (push_m) sb_q.push_back({flg, din});
    if (clr) sb_q.delete();
    if (ovr_m) model_oe = 1'b1;
    else if (lsr) model_oe = 1'b0;
    @(posedge CLK);
    #1;
    bus.RXFINISHED = 1'b0;
    bus.RD         = 1'b0;
    bus.LSRREAD    = 1'b0;
    bus.CLEAR      = 1'b0;
    {bus.BII, bus.FEI, bus.PEI} = 3'b000;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.RXCLK = 1'b1;
      @(posedge CLK);
      #1;
      bus.RXCLK = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] f);
    cyc(1'b1, d, f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_usage"},   32'(bus.USAGE),     32'd0);
    check({tag, "_empty"},   32'(bus.EMPTY),     32'd1);
    check({tag, "_full"},    32'(bus.FULL),      32'd0);
    check({tag, "_oe"},      32'(bus.OE),        32'd0);
    check({tag, "_err"},     32'(bus.ERRINFIFO), 32'd0);
    check({tag, "_timeout"}, 32'(bus.TIMEOUT),   32'd0);
    check({tag, "_trigger"}, 32'(bus.TRIGGER),   32'd0);
    check({tag, "_dout"},    32'(head_word()),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RXCLK = 1'b0; bus.FIFOE = 1'b1; bus.CLEAR = 1'b0; bus.TL = 2'b11;
    bus.WLS = 2'b11; bus.PEN = 1'b0; bus.STB = 1'b0;
    bus.DIN = 8'h00; bus.PEI = 1'b0; bus.FEI = 1'b0; bus.BII = 1'b0;
    bus.RXFINISHED = 1'b0; bus.RD = 1'b0; bus.LSRREAD = 1'b0;

    //            fifoe rxf   din    flg     rd    lsr   clr   usage empty full  oe    err   chkd  dout
    vecs[0]  = '{1'b1, 1'b1, 8'h41, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h041};
    vecs[1]  = '{1'b1, 1'b1, 8'h42, 3'b010, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h041};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h242};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[5]  = '{1'b0, 1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h011};
    vecs[6]  = '{1'b0, 1'b1, 8'h22, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h011};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h011};
    vecs[8]  = '{1'b0, 1'b1, 8'h33, 3'b000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h033};
    vecs[9]  = '{1'b0, 1'b1, 8'h44, 3'b000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h033};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h033};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Vector table: basic push/pop, error flags, FIFOE=0 overrun, OE priority.
    for (int i = 0; i < 12; i++) begin
      bus.FIFOE = vecs[i].fifoe;
      cyc(vecs[i].rxf, vecs[i].din, vecs[i].flg, vecs[i].rd, vecs[i].lsr, vecs[i].clr);
      check($sformatf("vec%0d_usage", i), 32'(bus.USAGE),     32'(vecs[i].e_usage));
      check($sformatf("vec%0d_empty", i), 32'(bus.EMPTY),     32'(vecs[i].e_empty));
      check($sformatf("vec%0d_full", i),  32'(bus.FULL),      32'(vecs[i].e_full));
      check($sformatf("vec%0d_oe", i),    32'(bus.OE),        32'(vecs[i].e_oe));
      check($sformatf("vec%0d_err", i),   32'(bus.ERRINFIFO), 32'(vecs[i].e_err));
      if (vecs[i].chk_dout)
        check($sformatf("vec%0d_dout", i), 32'(head_word()), 32'(vecs[i].e_dout));
    end

    // Simultaneous push and pop of erroneous entries keeps the error count.
    bus.FIFOE = 1'b1;
    push(8'h51, 3'b001);
    cyc(1'b1, 8'h52, 3'b100, 1'b1, 1'b0, 1'b0);
    check("errpp_err", 32'(bus.ERRINFIFO), 32'd1);
    check("errpp_usage", 32'(bus.USAGE), 32'd1);
    pop1();
    check("errpp_drain", 32'(bus.ERRINFIFO), 32'd0);

    // Fill to 16 with TL=14 trigger, then overrun.
    bus.TL = 2'b11;
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 3'b000);
      if (i == 12) check("trig14_at13", 32'(bus.TRIGGER), 32'd0);
      if (i == 13) check("trig14_at14", 32'(bus.TRIGGER), 32'd1);
    end
    check("fill_full", 32'(bus.FULL), 32'd1);
    check("fill_usage", 32'(bus.USAGE), 32'd16);
    push(8'hFF, 3'b000);
    check("ovr_oe", 32'(bus.OE), 32'(model_oe));
    check("ovr_oe_set", 32'(bus.OE), 32'd1);
    check("ovr_usage", 32'(bus.USAGE), 32'd16);
    check("ovr_dout", 32'(head_word()), 32'h000);
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
    check("lsr_clr_oe", 32'(bus.OE), 32'd0);

    // Full with pop and push together: no overrun, 0xAA lands 16th.
    cyc(1'b1, 8'hAA, 3'b000, 1'b1, 1'b0, 1'b0);
    check("fullpp_oe", 32'(bus.OE), 32'd0);
    check("fullpp_usage", 32'(bus.USAGE), 32'd16);
    for (int i = 0; i < 16; i++) pop1();
    check("drain_empty", 32'(bus.EMPTY), 32'd1);
    check("drain_sb", 32'(sb_q.size()), 32'd0);

    // Empty with pop and push together: push accepted only.
    cyc(1'b1, 8'hAA, 3'b000, 1'b1, 1'b0, 1'b0);
    check("emptypp_usage", 32'(bus.USAGE), 32'd1);
    check("emptypp_dout", 32'(head_word()), 32'h0AA);
    pop1();

    // Other trigger levels.
    bus.TL = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push(8'h80 + 8'(i), 3'b000);
      if (i == 2) check("trig4_at3", 32'(bus.TRIGGER), 32'd0);
      if (i == 3) check("trig4_at4", 32'(bus.TRIGGER), 32'd1);
    end
    bus.TL = 2'b10;
    #1 check("trig8_at4", 32'(bus.TRIGGER), 32'd0);
    for (int i = 0; i < 3; i++) pop1();
    bus.TL = 2'b00;
    #1 check("trig1_at1", 32'(bus.TRIGGER), 32'd1);
    pop1();
    check("trig1_at0", 32'(bus.TRIGGER), 32'd0);

    // Character timeout: 10-bit characters -> 640 ticks.
    bus.WLS = 2'b11; bus.PEN = 1'b0; bus.STB = 1'b0;
    push(8'h5A, 3'b000);
    tick(639);
    check("tmo_639", 32'(bus.TIMEOUT), 32'd0);
    tick(1);
    check("tmo_640", 32'(bus.TIMEOUT), 32'd1);
    pop1();
    check("tmo_rd_clr", 32'(bus.TIMEOUT), 32'd0);
    tick(700);
    check("tmo_empty", 32'(bus.TIMEOUT), 32'd0);
    push(8'h5B, 3'b000);
    tick(639);
    push(8'h5C, 3'b000);
    tick(639);
    check("tmo_restart_639", 32'(bus.TIMEOUT), 32'd0);
    tick(1);
    check("tmo_restart_640", 32'(bus.TIMEOUT), 32'd1);
    bus.FIFOE = 1'b0;
    #1 check("tmo_fifoe0", 32'(bus.TIMEOUT), 32'd0);
    bus.FIFOE = 1'b1;
    bus.WLS = 2'b00;
    #1 check("tmo_short_limit", 32'(bus.TIMEOUT), 32'd1);
    bus.WLS = 2'b11;
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    check("tmo_clear", 32'(bus.TIMEOUT), 32'd0);
    check("tmo_clear_usage", 32'(bus.USAGE), 32'd0);

    // CLEAR with simultaneous push while OE is set.
    bus.FIFOE = 1'b0;
    push(8'h61, 3'b000);
    push(8'h62, 3'b000);
    bus.FIFOE = 1'b1;
    push(8'h63, 3'b000);
    push(8'h64, 3'b010);
    check("preclr_usage", 32'(bus.USAGE), 32'd3);
    check("preclr_err", 32'(bus.ERRINFIFO), 32'd1);
    cyc(1'b1, 8'h65, 3'b000, 1'b0, 1'b0, 1'b1);
    check("clr_usage", 32'(bus.USAGE), 32'd0);
    check("clr_empty", 32'(bus.EMPTY), 32'd1);
    check("clr_oe", 32'(bus.OE), 32'd1);
    check("clr_err", 32'(bus.ERRINFIFO), 32'd0);
    push(8'h66, 3'b000);
    check("postclr_dout", 32'(head_word()), 32'h066);
    check("postclr_usage", 32'(bus.USAGE), 32'd1);

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i), 3'b111);
    check("prerst_usage", 32'(bus.USAGE), 32'd5);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("async_rst");
    sb_q.delete();
    model_oe = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    push(8'h99, 3'b000);
    check("postrst_dout", 32'(head_word()), 32'h099);
    pop1();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
